// File: rtl/pc_pkg.sv
// pc_pkg: definitions shared by the PC jump unit and its jump table.
//   jmp_mode_t      - encoding of the jmp_mode input (REL, ABS, CALL, RET)
//   SP_W            - width of the sp_depth output
//   default_entry() - reset image of the jump table, as a signed 32-bit value
//                     that callers truncate to the table data width
package pc_pkg;

  typedef enum logic [1:0] {
    REL  = 2'd0,
    ABS  = 2'd1,
    CALL = 2'd2,
    RET  = 2'd3
  } jmp_mode_t;

  localparam int SP_W = 5;

  // The first six entries reproduce the legacy fixed target decode. Every
  // other entry starts at zero. Truncating the signed value to D bits yields
  // the D-bit two's-complement offset.
  function automatic logic [31:0] default_entry(input int idx);
    case (idx)
      0:       default_entry = -32'sd5;
      1:       default_entry = 32'sd20;
      2:       default_entry = -32'sd1;
      3:       default_entry = -32'sd20;
      4:       default_entry = -32'sd3;
      5:       default_entry = 32'sd2;
      default: default_entry = 32'd0;
    endcase
  endfunction

endpackage

// File: rtl/pc_jump_unit_table.sv
// jump_table: 2^AW x D jump-offset / absolute-target table.
//   clk, reset : clock and asynchronous active-high reset; reset loads the
//                default image
//   we, waddr, wdata : one synchronous write port
//   raddr -> rdata   : combinational read port
// A read of the entry being written in the same cycle returns the old value,
// because the write only takes effect at the clock edge.
module jump_table
  import pc_pkg::*;
#(
  parameter int D  = 12,
  parameter int AW = 6
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [D-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [D-1:0]  rdata
);

  localparam int DEPTH = 1 << AW;

  logic [D-1:0] mem_reg    [DEPTH];
  logic [D-1:0] init_image [DEPTH];

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_init
      assign init_image[gi] = D'(default_entry(gi));
    end
  endgenerate

  // Reset restores the whole image, so the table is kept in registers rather
  // than in block RAM.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_reg[i] <= init_image[i];
      end
    end else if (we) begin
      mem_reg[waddr] <= wdata;
    end
  end

  assign rdata = mem_reg[raddr];

endmodule

// File: rtl/pc_jump_unit.sv
// pc_jump_unit: program counter with a programmable jump table, relative and
// absolute jumps, and a small call/return stack.
//   clk, reset         : clock and asynchronous active-high reset
//   stall              : freezes pc, stack and error flag (table writes proceed)
//   jmp_en, jmp_mode   : jump request and its kind (REL/ABS/CALL/RET)
//   addr               : table index used by REL, ABS and CALL
//   lut_we/waddr/wdata : table write port
//   pc                 : registered program counter
//   sp_depth           : number of valid call-stack entries (0..SD)
//   stk_err            : sticky overflow/underflow flag
module pc_jump_unit
  import pc_pkg::*;
#(
  parameter int D  = 12,
  parameter int AW = 6,
  parameter int SD = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          stall,
  input  logic          jmp_en,
  input  logic [1:0]    jmp_mode,
  input  logic [AW-1:0] addr,
  input  logic          lut_we,
  input  logic [AW-1:0] lut_waddr,
  input  logic [D-1:0]  lut_wdata,
  output logic [D-1:0]  pc,
  output logic [4:0]    sp_depth,
  output logic          stk_err
);

  localparam logic [SP_W-1:0] SD_L = SP_W'(SD);

  logic [D-1:0]      pc_reg, pc_next;
  logic [SP_W-1:0]   sp_reg, sp_next;
  logic              err_reg, err_next;
  logic              push;
  logic [D-1:0]      stack_reg [SD];
  logic [D-1:0]      stack_top;
  logic [D-1:0]      table_data;
  logic [D-1:0]      pc_plus1;
  logic [D-1:0]      pc_rel;
  logic [SP_W-1:0]   sp_minus1;
  jmp_mode_t         mode;

  jump_table #(
    .D  (D),
    .AW (AW)
  ) u_table (
    .clk   (clk),
    .reset (reset),
    .we    (lut_we),
    .waddr (lut_waddr),
    .wdata (lut_wdata),
    .raddr (addr),
    .rdata (table_data)
  );

  assign mode      = jmp_mode_t'(jmp_mode);
  assign pc_plus1  = pc_reg + D'(1);
  // Unsigned D-bit addition of a two's-complement offset wraps in both
  // directions, which is exactly the modulo-2^D behaviour wanted.
  assign pc_rel    = pc_reg + table_data;
  assign sp_minus1 = sp_reg - SP_W'(1);

  // Top of stack lives at index sp-1. A compare-select avoids indexing the
  // SD-entry array with the wider depth counter.
  always_comb begin
    stack_top = '0;
    for (int i = 0; i < SD; i++) begin
      if (sp_minus1 == SP_W'(i)) begin
        stack_top = stack_reg[i];
      end
    end
  end

  always_comb begin
    pc_next  = pc_reg;
    sp_next  = sp_reg;
    err_next = err_reg;
    push     = 1'b0;
    if (!stall) begin
      if (jmp_en) begin
        case (mode)
          REL: pc_next = pc_rel;
          ABS: pc_next = table_data;
          CALL: begin
            // On overflow the return address is lost but the jump still happens.
            if (sp_reg < SD_L) begin
              push    = 1'b1;
              sp_next = sp_reg + SP_W'(1);
            end else begin
              err_next = 1'b1;
            end
            pc_next = pc_rel;
          end
          RET: begin
            if (sp_reg != '0) begin
              pc_next = stack_top;
              sp_next = sp_minus1;
            end else begin
              pc_next  = pc_plus1;
              err_next = 1'b1;
            end
          end
          default: pc_next = pc_plus1;
        endcase
      end else begin
        pc_next = pc_plus1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_reg  <= '0;
      sp_reg  <= '0;
      err_reg <= 1'b0;
    end else begin
      pc_reg  <= pc_next;
      sp_reg  <= sp_next;
      err_reg <= err_next;
    end
  end

  // Stack contents need no reset: only entries below sp_depth are ever read,
  // and popped entries are simply left behind.
  always_ff @(posedge clk) begin
    for (int i = 0; i < SD; i++) begin
      if (push && sp_reg == SP_W'(i)) begin
        stack_reg[i] <= pc_plus1;
      end
    end
  end

  assign pc       = pc_reg;
  assign sp_depth = sp_reg;
  assign stk_err  = err_reg;

endmodule

// File: tb/tb_pc_jump_unit.sv
module tb_pc_jump_unit;

  localparam int D    = 12;
  localparam int AW   = 6;
  localparam int SD   = 4;
  localparam int MASK = (1 << D) - 1;
  localparam int NT   = 1 << AW;

  localparam logic [1:0] M_REL  = 2'd0;
  localparam logic [1:0] M_ABS  = 2'd1;
  localparam logic [1:0] M_CALL = 2'd2;
  localparam logic [1:0] M_RET  = 2'd3;

  logic          clk = 1'b0;
  logic          reset;
  logic          stall;
  logic          jmp_en;
  logic [1:0]    jmp_mode;
  logic [AW-1:0] addr;
  logic          lut_we;
  logic [AW-1:0] lut_waddr;
  logic [D-1:0]  lut_wdata;
  logic [D-1:0]  pc;
  logic [4:0]    sp_depth;
  logic          stk_err;

  pc_jump_unit #(.D(D), .AW(AW), .SD(SD)) dut (
    .clk       (clk),
    .reset     (reset),
    .stall     (stall),
    .jmp_en    (jmp_en),
    .jmp_mode  (jmp_mode),
    .addr      (addr),
    .lut_we    (lut_we),
    .lut_waddr (lut_waddr),
    .lut_wdata (lut_wdata),
    .pc        (pc),
    .sp_depth  (sp_depth),
    .stk_err   (stk_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int pc;
    int depth;
    int err;
    int seq;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   seq_no   = 0;

  // Reference model: plain integers, a queue for the stack, an int table.
  int   m_pc;
  int   m_err;
  int   m_stack[$];
  int   m_tbl[NT];

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  task automatic model_reset();
    m_pc  = 0;
    m_err = 0;
    m_stack.delete();
    for (int i = 0; i < NT; i++) m_tbl[i] = 0;
    m_tbl[0] = -5 & MASK;
    m_tbl[1] = 20;
    m_tbl[2] = -1 & MASK;
    m_tbl[3] = -20 & MASK;
    m_tbl[4] = -3 & MASK;
    m_tbl[5] = 2;
  endtask

  // Called at a falling edge: apply inputs for the next rising edge, predict
  // the outcome, queue it for the monitor, then move to the next falling edge.
  task automatic step(input bit st, input bit en, input logic [1:0] md,
                      input int a, input bit we, input int wa, input int wd);
    exp_t e;
    int   t;
    stall = st; jmp_en = en; jmp_mode = md; addr = AW'(a);
    lut_we = we; lut_waddr = AW'(wa); lut_wdata = D'(wd);
    t = m_tbl[a];
    if (!st) begin
      if (!en) m_pc = (m_pc + 1) & MASK;
      else begin
        case (md)
          M_REL: m_pc = (m_pc + t) & MASK;
          M_ABS: m_pc = t;
          M_CALL: begin
            if (m_stack.size() < SD) m_stack.push_back((m_pc + 1) & MASK);
            else m_err = 1;
            m_pc = (m_pc + t) & MASK;
          end
          default: begin
            if (m_stack.size() > 0) m_pc = m_stack.pop_back();
            else begin
              m_pc  = (m_pc + 1) & MASK;
              m_err = 1;
            end
          end
        endcase
      end
    end
    if (we) m_tbl[wa] = wd & MASK;
    e.pc = m_pc; e.depth = m_stack.size(); e.err = m_err; e.seq = seq_no++;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic idle();
    stall = 0; jmp_en = 0; jmp_mode = M_REL; addr = '0;
    lut_we = 0; lut_waddr = '0; lut_wdata = '0;
  endtask

  // Called at a falling edge; the asynchronous reset must act before any edge.
  task automatic do_reset();
    idle();
    reset = 1'b1;
    #1;
    chk("reset_pc", int'(pc), 0);
    chk("reset_depth", int'(sp_depth), 0);
    chk("reset_err", int'(stk_err), 0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Monitor: every rising edge with an outstanding prediction is a response.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk($sformatf("pc[%0d]", e.seq), int'(pc), e.pc);
        chk($sformatf("depth[%0d]", e.seq), int'(sp_depth), e.depth);
        chk($sformatf("err[%0d]", e.seq), int'(stk_err), e.err);
        $display("txn %0d pc=0x%03h depth=%0d err=%0d", e.seq, pc, sp_depth, stk_err);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    idle();
    model_reset();
    @(negedge clk);
    do_reset();

    // increment 1,2,3,4 then REL by T[2] = -1
    repeat (4) step(0, 0, M_REL, 0, 0, 0, 0);
    step(0, 1, M_REL, 2, 0, 0, 0);
    // reach pc=2, REL by -5 wraps below zero
    step(0, 0, M_REL, 0, 1, 11, 2);
    step(0, 1, M_ABS, 11, 0, 0, 0);
    step(0, 1, M_REL, 0, 0, 0, 0);
    // reach 0xFF0, REL by +20 wraps above the top
    step(0, 0, M_REL, 0, 1, 12, 'hFF0);
    step(0, 1, M_ABS, 12, 0, 0, 0);
    step(0, 1, M_REL, 1, 0, 0, 0);
    // read-during-write returns the old value, then the new one
    step(0, 1, M_ABS, 9, 1, 9, 'h123);
    step(0, 1, M_ABS, 9, 0, 0, 0);
    // CALL at pc=10 via T[5]=+2, then RET
    step(0, 0, M_REL, 0, 1, 13, 10);
    step(0, 1, M_ABS, 13, 0, 0, 0);
    step(0, 1, M_CALL, 5, 0, 0, 0);
    step(0, 1, M_RET, 0, 0, 0, 0);
    // nested calls to full depth, one overflow, then unwind
    for (int i = 0; i < SD + 1; i++) step(0, 1, M_CALL, 1 + (i % 2), 0, 0, 0);
    for (int i = 0; i < SD; i++) step(0, 1, M_RET, 0, 0, 0, 0);
    // underflow after a fresh reset
    do_reset();
    step(0, 1, M_RET, 0, 0, 0, 0);
    // stall holds everything while a CALL is requested
    step(0, 1, M_CALL, 1, 0, 0, 0);
    step(1, 1, M_CALL, 1, 0, 0, 0);
    step(1, 1, M_CALL, 3, 1, 20, 'h55);
    step(0, 1, M_ABS, 20, 0, 0, 0);
    // overwrite T[0], reset mid-sequence, confirm the default -5 is back
    step(0, 1, M_CALL, 4, 1, 0, 'h100);
    do_reset();
    step(0, 1, M_REL, 0, 0, 0, 0);

    // randomized traffic with occasional resets
    for (int n = 0; n < 400; n++) begin
      bit st, en, we;
      st = ($urandom_range(0, 9) < 2);
      en = ($urandom_range(0, 9) < 6);
      we = ($urandom_range(0, 9) < 3);
      step(st, en, 2'($urandom_range(0, 3)), $urandom_range(0, 7),
           we, $urandom_range(0, 7), $urandom_range(0, MASK));
      if (n % 150 == 149) do_reset();
    end

    idle();
    @(negedge clk);
    @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
